snoop_resp_ctrl_md: RTL and testbench
=====================================

# snoop_resp_ctrl_md

Snoop-side response controller for one L1 cache. It sits directly downstream of the snoop tag-match stage and consumes its per-way hit vector together with the snooped MESI states. It answers BusRd/BusRdX with a shared indication and, for Modified lines, a data flush handshake. It then writes the resulting MESI state back to the tag/state array, stalling the bus through the busy signal until the transaction completes.

## Interface
- ASSOC, 4, ways per set
- ASSOC_WID, 2, log2(ASSOC)
- MESI_WID, 2, MESI state width
- DATA_WID, 32, flushed line data width
- FLUSH_TO, 15, max cycles waiting for flush_ack; FLUSH_TO ≥ 1

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bus_rd  in  1  snooped BusRd
- bus_rdx  in  1  snooped BusRdX
- access_blk_snoop  in  ASSOC  per-way snoop hit vector, expected one-hot or zero
- cache_snoop_mesi  in  ASSOC*MESI_WID  MESI state per way, way i at [i*MESI_WID +: MESI_WID]
- snoop_data_in  in  DATA_WID  data array read data, valid the cycle after snoop_rd_en
- flush_ack  in  1  bus accepted flush data
- snoop_busy  out  1  transaction in progress, bus must hold
- shared  out  1  line present in this cache
- snoop_rd_en  out  1  data array read strobe
- snoop_way  out  ASSOC_WID  way being read/updated
- bus_flush_req  out  1  flush data valid on bus
- flush_data  out  DATA_WID  registered flush data
- mesi_wr_en  out  1  MESI write strobe, single cycle
- mesi_wr_state  out  MESI_WID  new MESI state for snoop_way
- snoop_done  out  1  single-cycle completion pulse
- snoop_err  out  1  single-cycle error pulse: multi-hit or flush timeout

## Operation
- MESI encoding: I=0, S=1, E=2, M=3.
- FSM states:
  - IDLE
  - READ: snoop_rd_en=1
  - DATA: load flush_data from snoop_data_in
  - FLUSH: bus_flush_req=1
  - UPDATE: mesi_wr_en=1, snoop_done=1
- IDLE accepts a request when (bus_rd|bus_rdx) and access_blk_snoop≠0. It latches:
  - op: rdx wins if both bus_rd and bus_rdx are high
  - way: lowest set bit of the hit vector
  - the MESI state of that way
- Multi-hit pulses snoop_err in the cycle after acceptance; processing still uses the lowest way.
- A miss or no request leaves the FSM in IDLE with no outputs. Inputs are ignored outside IDLE.
- Latched state M goes IDLE→READ→DATA→FLUSH→UPDATE.
- Latched state S or E goes IDLE→UPDATE.
- mesi_wr_state is S for BusRd and I for BusRdX.
- shared is high from the cycle after a BusRd acceptance through UPDATE inclusive. It is never asserted for BusRdX.
- In FLUSH, bus_flush_req and flush_data stay stable until flush_ack is sampled high, then the FSM moves to UPDATE.
- A down-counter loads FLUSH_TO on entering FLUSH. If it reaches 0 without flush_ack, the FSM pulses snoop_err and goes to UPDATE, still writing the new state.
- snoop_busy = (state ≠ IDLE).

## Timing
- All outputs are registered or decoded from state, with no combinational input-to-output paths.
- Reset value of every output is 0; the FSM resets to IDLE.
- With the request accepted at edge T:
  - S/E: UPDATE during T+1, back in IDLE at T+2. Latency is 1 cycle.
  - M: READ T+1, DATA T+2, FLUSH from T+3. If flush_ack arrives in cycle F, UPDATE is F+1 and IDLE is F+2. Minimum latency is 4 cycles.
- A new request can be accepted in the first IDLE cycle after UPDATE.
- flush_ack outside FLUSH is ignored.
- Reset mid-transaction aborts immediately: bus_flush_req drops asynchronously and no MESI write occurs.

## Structure
- Shared package mesi_pkg holds:
  - typedef enum logic [1:0] mesi_t {I, S, E, M}
  - the snoop FSM state enum
- Sub-module prio_enc_md (ASSOC → ASSOC_WID lowest-set-bit encoder with multi-hit flag), reusable on the processor-side hit path.

## Test plan
- BusRd, hit vector 0100, way 2 state E → shared high T+1, mesi_wr_en T+1 with way=2, state=S, snoop_done T+1, busy for 1 cycle.
- BusRdX, hit vector 0001, state M, data 0xDEADBEEF, flush_ack after 3 FLUSH cycles:
  - snoop_rd_en T+1
  - bus_flush_req T+3..T+5 with flush_data=0xDEADBEEF
  - UPDATE T+6 with state=I, shared never high
- BusRd with hit vector 0000 → no outputs, FSM stays IDLE.
- Hit vector 1010 with state S → snoop_err pulse T+1, way 1 updated to S.
- State M, flush_ack never asserted, FLUSH_TO=15 → snoop_err after 15 FLUSH cycles, then UPDATE.
- rst_n asserted low during FLUSH → all outputs 0 immediately, no mesi_wr_en, next request handled normally.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared MESI and snoop-FSM types for the snoop response controller and
// the processor-side hit path.
package mesi_pkg;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        E = 2'd2,
        M = 2'd3
    } mesi_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_DATA   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_UPDATE = 3'd4
    } snoop_state_t;

endpackage

// File: rtl/prio_enc_md.sv
// Lowest-set-bit encoder with any-hit and multi-hit flags.
module prio_enc_md #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o,
    output logic         multi_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o = vec_i[i] ? W'(i) : idx_o;
        end
    end

    assign any_o   = |vec_i;
    assign multi_o = |(vec_i & (vec_i - N'(1)));

endmodule

// File: rtl/snoop_resp_ctrl_md.sv
// Snoop response controller: answers BusRd/BusRdX, flushes Modified lines
// and writes the downgraded MESI state back to the tag/state array.
module snoop_resp_ctrl_md
    import mesi_pkg::*;
#(
    parameter int ASSOC     = 4,
    parameter int ASSOC_WID = 2,
    parameter int MESI_WID  = 2,
    parameter int DATA_WID  = 32,
    parameter int FLUSH_TO  = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bus_rd,
    input  logic                      bus_rdx,
    input  logic [ASSOC-1:0]          access_blk_snoop,
    input  logic [ASSOC*MESI_WID-1:0] cache_snoop_mesi,
    input  logic [DATA_WID-1:0]       snoop_data_in,
    input  logic                      flush_ack,
    output logic                      snoop_busy,
    output logic                      shared,
    output logic                      snoop_rd_en,
    output logic [ASSOC_WID-1:0]      snoop_way,
    output logic                      bus_flush_req,
    output logic [DATA_WID-1:0]       flush_data,
    output logic                      mesi_wr_en,
    output logic [MESI_WID-1:0]       mesi_wr_state,
    output logic                      snoop_done,
    output logic                      snoop_err
);

    localparam int CNT_WID = $clog2(FLUSH_TO + 1);

    snoop_state_t          state_q, state_d;
    logic                  op_rdx_q, op_rdx_d;
    logic [ASSOC_WID-1:0]  way_q, way_d;
    logic [CNT_WID-1:0]    cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WID-1:0]   flush_data_q, flush_data_d;

    logic [ASSOC_WID-1:0]  hit_way_s;
    logic                  hit_any_s;
    logic                  hit_multi_s;
    mesi_t                 hit_mesi_s;

    prio_enc_md #(
        .N (ASSOC),
        .W (ASSOC_WID)
    ) u_prio_enc (
        .vec_i   (access_blk_snoop),
        .idx_o   (hit_way_s),
        .any_o   (hit_any_s),
        .multi_o (hit_multi_s)
    );

    assign hit_mesi_s = mesi_t'(cache_snoop_mesi[hit_way_s*MESI_WID +: MESI_WID]);

    // Next-state logic; the transaction path is fixed at acceptance time.
    always_comb begin
        state_d      = state_q;
        op_rdx_d     = op_rdx_q;
        way_d        = way_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        flush_data_d = flush_data_q;
        case (state_q)
            ST_IDLE: begin
                if ((bus_rd || bus_rdx) && hit_any_s) begin
                    op_rdx_d = bus_rdx;
                    way_d    = hit_way_s;
                    err_d    = hit_multi_s;
                    state_d  = (hit_mesi_s == M) ? ST_READ : ST_UPDATE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                flush_data_d = snoop_data_in;
                cnt_d        = CNT_WID'(FLUSH_TO);
                state_d      = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Ack wins over a timeout landing in the same cycle.
                if (flush_ack) begin
                    state_d = ST_UPDATE;
                end else if (cnt_q <= CNT_WID'(1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d   = cnt_q - CNT_WID'(1);
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_rdx_q     <= 1'b0;
            way_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            flush_data_q <= '0;
        end else begin
            state_q      <= state_d;
            op_rdx_q     <= op_rdx_d;
            way_q        <= way_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            flush_data_q <= flush_data_d;
        end
    end

    assign snoop_busy    = (state_q != ST_IDLE);
    assign shared        = snoop_busy && !op_rdx_q;
    assign snoop_rd_en   = (state_q == ST_READ);
    assign snoop_way     = way_q;
    assign bus_flush_req = (state_q == ST_FLUSH);
    assign flush_data    = flush_data_q;
    assign mesi_wr_en    = (state_q == ST_UPDATE);
    assign snoop_done    = (state_q == ST_UPDATE);
    assign snoop_err     = err_q;
    assign mesi_wr_state = (state_q == ST_UPDATE)
                         ? (op_rdx_q ? MESI_WID'(I) : MESI_WID'(S))
                         : '0;

endmodule

// File: tb/tb_snoop_resp_ctrl_md.sv
// Scoreboard bench for snoop_resp_ctrl_md: directed transactions push their
// expected outcome; a monitor pops and compares on each snoop_done.
module tb_snoop_resp_ctrl_md;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_rd = 1'b0;
    logic        bus_rdx = 1'b0;
    logic [3:0]  access_blk_snoop = 4'd0;
    logic [7:0]  cache_snoop_mesi = 8'd0;
    logic [31:0] snoop_data_in = 32'd0;
    logic        flush_ack = 1'b0;
    logic        snoop_busy, shared, snoop_rd_en, bus_flush_req;
    logic [1:0]  snoop_way;
    logic [31:0] flush_data;
    logic        mesi_wr_en;
    logic [1:0]  mesi_wr_state;
    logic        snoop_done, snoop_err;

    typedef struct {
        logic [1:0]  way;
        logic [1:0]  st;
        int          lat;
        int          fc;
        int          rd;
        int          err;
        logic        shr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    snoop_resp_ctrl_md #(
        .ASSOC(4), .ASSOC_WID(2), .MESI_WID(2), .DATA_WID(32), .FLUSH_TO(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_rd(bus_rd), .bus_rdx(bus_rdx),
        .access_blk_snoop(access_blk_snoop), .cache_snoop_mesi(cache_snoop_mesi),
        .snoop_data_in(snoop_data_in), .flush_ack(flush_ack),
        .snoop_busy(snoop_busy), .shared(shared), .snoop_rd_en(snoop_rd_en),
        .snoop_way(snoop_way), .bus_flush_req(bus_flush_req), .flush_data(flush_data),
        .mesi_wr_en(mesi_wr_en), .mesi_wr_state(mesi_wr_state),
        .snoop_done(snoop_done), .snoop_err(snoop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, snoop_busy, 0);
        chk({tag, "_shared"}, shared, 0);
        chk({tag, "_rd_en"}, snoop_rd_en, 0);
        chk({tag, "_flush_req"}, bus_flush_req, 0);
        chk({tag, "_wr_en"}, mesi_wr_en, 0);
        chk({tag, "_wr_state"}, mesi_wr_state, 0);
        chk({tag, "_done"}, snoop_done, 0);
        chk({tag, "_err"}, snoop_err, 0);
    endtask

    // Monitor: accumulate per-transaction observations, compare on done.
    int   lat_c = 0, fc_c = 0, rd_c = 0, err_c = 0;
    logic shr_c = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            lat_c = 0; fc_c = 0; rd_c = 0; err_c = 0; shr_c = 1'b0;
        end else begin
            if (snoop_busy) lat_c++;
            if (shared) shr_c = 1'b1;
            if (snoop_rd_en) rd_c++;
            if (snoop_err) err_c++;
            if (bus_flush_req) begin
                fc_c++;
                chk("flush_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("flush_data", flush_data, exp_q[0].data);
            end
            if (snoop_done) begin
                chk("wr_en_with_done", mesi_wr_en, 1);
                chk("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("way", snoop_way, cur.way);
                    chk("wr_state", mesi_wr_state, cur.st);
                    chk("latency", lat_c, cur.lat);
                    chk("flush_cycles", fc_c, cur.fc);
                    chk("rd_cycles", rd_c, cur.rd);
                    chk("err_pulses", err_c, cur.err);
                    chk("shared", shr_c, cur.shr);
                end
                lat_c = 0; fc_c = 0; rd_c = 0; err_c = 0; shr_c = 1'b0;
            end
        end
    end

    task automatic run(input logic rd, input logic rdx, input logic [3:0] hit,
                       input logic [7:0] mv, input logic [31:0] data,
                       input int ack_at, input logic ack_hold, input exp_t e);
        int   fc;
        logic fin;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus_rd = rd; bus_rdx = rdx; access_blk_snoop = hit;
        cache_snoop_mesi = mv; snoop_data_in = data; flush_ack = ack_hold;
        @(posedge clk); #1;
        bus_rd = 1'b0; bus_rdx = 1'b0; access_blk_snoop = 4'd0;
        fc = 0; fin = 1'b0;
        for (int k = 0; k < 60 && !fin; k++) begin
            if (!snoop_busy) begin
                fin = 1'b1;
            end else begin
                if (bus_flush_req) fc++;
                flush_ack = ack_hold || (ack_at != 0 && bus_flush_req && fc == ack_at);
                @(posedge clk); #1;
            end
        end
        flush_ack = 1'b0;
        chk("txn_complete", fin, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic reached;
        #12;
        chk_idle_outputs("reset");
        chk("reset_flush_data", flush_data, 0);
        chk("reset_way", snoop_way, 0);
        #3 rst_n = 1'b1;

        // BusRd on E line in way 2.
        run(1'b1, 1'b0, 4'b0100, 8'h20, 32'h0, 0, 1'b0,
            '{way: 2'd2, st: 2'd1, lat: 1, fc: 0, rd: 0, err: 0, shr: 1'b1, data: 32'h0});
        // BusRdX on M line in way 0, ack in third FLUSH cycle.
        run(1'b0, 1'b1, 4'b0001, 8'h03, 32'hDEADBEEF, 3, 1'b0,
            '{way: 2'd0, st: 2'd0, lat: 6, fc: 3, rd: 1, err: 0, shr: 1'b0, data: 32'hDEADBEEF});

        // Miss: nothing happens.
        @(posedge clk); #1;
        bus_rd = 1'b1; access_blk_snoop = 4'd0; cache_snoop_mesi = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_idle_outputs("miss");
        end
        bus_rd = 1'b0;

        // Multi-hit 1010, all S: err pulse, lowest way 1.
        run(1'b1, 1'b0, 4'b1010, 8'h55, 32'h0, 0, 1'b0,
            '{way: 2'd1, st: 2'd1, lat: 1, fc: 0, rd: 0, err: 1, shr: 1'b1, data: 32'h0});
        // Flush timeout on M line in way 3.
        run(1'b1, 1'b0, 4'b1000, 8'hC0, 32'h12345678, 0, 1'b0,
            '{way: 2'd3, st: 2'd1, lat: 18, fc: 15, rd: 1, err: 1, shr: 1'b1, data: 32'h12345678});
        // rd and rdx together: rdx wins; stray flush_ack ignored.
        run(1'b1, 1'b1, 4'b0010, 8'h04, 32'h0, 0, 1'b1,
            '{way: 2'd1, st: 2'd0, lat: 1, fc: 0, rd: 0, err: 0, shr: 1'b0, data: 32'h0});

        // Reset during FLUSH.
        @(posedge clk); #1;
        bus_rd = 1'b1; access_blk_snoop = 4'b0001; cache_snoop_mesi = 8'h03;
        snoop_data_in = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_rd = 1'b0; access_blk_snoop = 4'd0;
        reached = 1'b0;
        for (int k = 0; k < 10 && !reached; k++) begin
            if (bus_flush_req) reached = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("flush_reached", reached, 1);
        chk("flush_data_pre_reset", flush_data, 32'hCAFEF00D);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        chk("abort_flush_data", flush_data, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("abort_no_wr", mesi_wr_en, 0);
        end
        #2 rst_n = 1'b1;

        // Normal M flush after reset, ack in first FLUSH cycle.
        run(1'b1, 1'b0, 4'b0001, 8'h03, 32'hA5A55A5A, 1, 1'b0,
            '{way: 2'd0, st: 2'd1, lat: 4, fc: 1, rd: 1, err: 0, shr: 1'b1, data: 32'hA5A55A5A});

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
